seq_bcd2bin_converter: RTL and testbench

SEQ_BCD2BIN_CONVERTER -- requirements
Module: seq_bcd2bin_converter

---
 rtl/seq_bcd2bin_converter.sv | 118 +++++++++++
 tb/tb_seq_bcd2bin_converter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/seq_bcd2bin_converter.sv
// seq_bcd2bin_converter: sequential signed BCD to two's-complement converter using reverse double dabble
module seq_bcd2bin_converter #(
    parameter int NUM_DIGITS  = 4,
    parameter int WIDTH       = 14,
    parameter bit CHECK_PARAM = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             negative,
    input  logic [3:0]       bcd [NUM_DIGITS],
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] bin,
    output logic             overflow,
    output logic             invalid
);
    localparam int MAG_WIDTH = 4 * NUM_DIGITS;
    localparam int CW        = $clog2(MAG_WIDTH + 1);
    localparam int XW        = (MAG_WIDTH > WIDTH ? MAG_WIDTH : WIDTH) + 1;
    localparam logic [XW-1:0] NEG_LIM = XW'(1) << (WIDTH - 1);
    localparam logic [XW-1:0] POS_MAX = NEG_LIM - XW'(1);

    generate
        if (CHECK_PARAM && (NUM_DIGITS == 0 || WIDTH < 2)) begin : g_bad_param
            $fatal(1, "seq_bcd2bin_converter: NUM_DIGITS must be > 0 and WIDTH >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, FINAL} state_t;

    state_t                   state, state_n;
    logic [CW-1:0]            cnt;
    logic [2*MAG_WIDTH-1:0]   sr, stepped;
    logic [MAG_WIDTH-1:0]     load_bcd;
    logic                     any_bad, sign, inv_cap, sat;
    logic [XW-1:0]            mag;
    logic [WIDTH-1:0]         res;

    assign busy = state != IDLE;

    // Flatten the digit array and flag any non-decimal digit at capture time
    always_comb begin
        load_bcd = '0;
        any_bad  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_bcd[4*i +: 4] = bcd[i];
            any_bad            = any_bad | (bcd[i] > 4'd9);
        end
    end

    // One reverse double-dabble step: shift right, then pull each digit >= 8 back by 3
    always_comb begin
        stepped = sr >> 1;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (stepped[MAG_WIDTH + 4*i +: 4] >= 4'd8)
                stepped[MAG_WIDTH + 4*i +: 4] = stepped[MAG_WIDTH + 4*i +: 4] - 4'd3;
    end

    // Apply sign and saturation to the finished magnitude; invalid input forces a zero result
    always_comb begin
        mag = XW'(sr[MAG_WIDTH-1:0]);
        sat = !inv_cap && (sign ? mag > NEG_LIM : mag > POS_MAX);
        res = inv_cap ? '0
            : sign ? (sat ? {1'b1, {(WIDTH-1){1'b0}}} : WIDTH'(XW'(0) - mag))
            : (sat ? {1'b0, {(WIDTH-1){1'b1}}} : WIDTH'(mag));
    end

    // Next-state logic
    always_comb begin
        state_n = (state == IDLE)  ? (start ? SHIFT : IDLE)
                : (state == SHIFT) ? (cnt == CW'(1) ? FINAL : SHIFT)
                : IDLE;
    end

    // State register, frozen while en is low
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else if (en)
            state <= state_n;
    end

    // Datapath and output registers, frozen while en is low
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            sr       <= '0;
            sign     <= 1'b0;
            inv_cap  <= 1'b0;
            done     <= 1'b0;
            bin      <= '0;
            overflow <= 1'b0;
            invalid  <= 1'b0;
        end else if (en) begin
            done <= state == FINAL;
            case (state)
                IDLE: if (start) begin
                    sr      <= {load_bcd, {MAG_WIDTH{1'b0}}};
                    sign    <= negative;
                    inv_cap <= any_bad;
                    cnt     <= CW'(MAG_WIDTH);
                end
                SHIFT: begin
                    sr  <= stepped;
                    cnt <= cnt - CW'(1);
                end
                FINAL: begin
                    bin      <= res;
                    overflow <= sat;
                    invalid  <= inv_cap;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_bcd2bin_converter.sv
// tb_seq_bcd2bin_converter: directed and swept checks of the signed BCD to binary converter
module tb_seq_bcd2bin_converter;
    logic        clk, rst, en, start, negative;
    logic [3:0]  bcd [4];
    logic        busy, done, overflow, invalid;
    logic [13:0] bin;
    int          n_cmp = 0, n_bad = 0;
    int          edges;
    logic        saw;
    logic [14:0] exp_v;

    seq_bcd2bin_converter #(.NUM_DIGITS(4), .WIDTH(14), .CHECK_PARAM(1)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .negative(negative), .bcd(bcd),
        .busy(busy), .done(done), .bin(bin), .overflow(overflow), .invalid(invalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input int v);
        int d = v;
        for (int i = 0; i < 4; i++) begin
            bcd[i] = 4'(d % 10);
            d = d / 10;
        end
    endtask

    task automatic go(input logic neg, output int n);
        negative = neg;
        start = 1'b1;
        n = 0;
        do begin
            tick();
            start = 1'b0;
            n++;
        end while (!done && n < 100);
    endtask

    task automatic conv(input int v, input logic neg, output int n);
        set_digits(v);
        go(neg, n);
    endtask

    function automatic logic [14:0] model(input int v, input logic neg);
        if (neg) return v > 8192 ? {1'b1, 14'h2000} : {1'b0, 14'(16384 - v)};
        return v > 8191 ? {1'b1, 14'h1FFF} : {1'b0, 14'(v)};
    endfunction

    initial begin
        rst = 1'b1; en = 1'b1; start = 1'b0; negative = 1'b0;
        set_digits(0);
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_bin", bin, 0);
        check("rst_ovf", overflow, 0);
        check("rst_inv", invalid, 0);
        rst = 1'b0;

        conv(1234, 1'b1, edges);
        check("n1234_lat", edges, 18);
        check("n1234_bin", bin, 14'h3B2E);
        check("n1234_ovf", overflow, 0);
        check("n1234_inv", invalid, 0);
        check("n1234_idle", busy, 0);
        tick();
        check("done_pulse", done, 0);

        conv(9999, 1'b0, edges);
        check("p9999_lat", edges, 18);
        check("p9999_bin", bin, 14'h1FFF);
        check("p9999_ovf", overflow, 1);

        conv(8192, 1'b1, edges);
        check("n8192_bin", bin, 14'h2000);
        check("n8192_ovf", overflow, 0);

        set_digits(1);
        bcd[1] = 4'hA;
        go(1'b0, edges);
        check("inv_lat", edges, 18);
        check("inv_flag", invalid, 1);
        check("inv_bin", bin, 0);
        check("inv_ovf", overflow, 0);

        conv(0, 1'b1, edges);
        check("n0_bin", bin, 0);
        check("n0_ovf", overflow, 0);
        check("n0_inv", invalid, 0);

        set_digits(4321);
        negative = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        repeat (4) begin tick(); edges++; end
        en = 1'b0;
        repeat (5) begin tick(); edges++; end
        check("stall_busy", busy, 1);
        check("stall_done", done, 0);
        en = 1'b1;
        while (!done && edges < 100) begin tick(); edges++; end
        check("stall_lat", edges, 23);
        check("stall_bin", bin, 14'h10E1);
        en = 1'b0;
        tick(); tick();
        check("hold_done", done, 1);
        check("hold_bin", bin, 14'h10E1);
        en = 1'b1;

        set_digits(1234);
        negative = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = 1;
        repeat (2) begin tick(); edges++; end
        set_digits(9999);
        start = 1'b1;
        tick();
        edges++;
        start = 1'b0;
        while (!done && edges < 100) begin tick(); edges++; end
        check("busy_start_lat", edges, 18);
        check("busy_start_bin", bin, 14'h04D2);
        check("busy_start_ovf", overflow, 0);

        set_digits(7777);
        negative = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_bin", bin, 0);
        check("abort_ovf", overflow, 0);
        check("abort_inv", invalid, 0);
        saw = 1'b0;
        repeat (25) begin tick(); saw = saw | done; end
        check("abort_no_done", saw, 0);

        conv(5, 1'b1, edges);
        check("fresh_lat", edges, 18);
        check("fresh_bin", bin, 14'h3FFB);

        conv(8191, 1'b0, edges);
        check("p8191_bin", bin, 14'h1FFF);
        check("p8191_ovf", overflow, 0);
        conv(8192, 1'b0, edges);
        check("p8192_ovf", overflow, 1);
        conv(8193, 1'b1, edges);
        check("n8193_bin", bin, 14'h2000);
        check("n8193_ovf", overflow, 1);

        for (int k = 0; k < 24; k++) begin
            int v;
            logic s;
            v = int'($urandom_range(0, 9999));
            s = 1'($urandom_range(0, 1));
            exp_v = model(v, s);
            conv(v, s, edges);
            check("sweep_lat", edges, 18);
            check($sformatf("sweep_bin_%0d_%0d", v, s), bin, exp_v[13:0]);
            check($sformatf("sweep_ovf_%0d_%0d", v, s), overflow, exp_v[14]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
